// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
// Collects request pulses into a pending register and hands out one encoded
// index per accepted valid/ready transfer. MODE 0 grants the highest pending
// index; MODE 1 grants round-robin, searching upward from a pointer that
// advances past each accepted index and wraps at N-1 (including for non
// power-of-2 N).
module pending_priority_encoder #(
   parameter int N    = 8,
   parameter int MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_i,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [$clog2(N)-1:0] out_idx,
   output logic [N-1:0]         pending_o,
   output logic                 collision_o
);

   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Index of the highest set bit; zero when the vector is empty.
   function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // First set bit at or above ptr; if none, wrap and take the lowest set bit.
   function automatic logic [IDX_W-1:0] rr_select(input logic [N-1:0]     vec,
                                                  input logic [IDX_W-1:0] ptr);
      logic [N-1:0] upper;
      upper = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= int'(ptr)) begin
            upper[i] = vec[i];
         end else begin
            upper[i] = 1'b0;
         end
      end
      if (|upper) begin
         return lowest_set(upper);
      end else begin
         return lowest_set(vec);
      end
   endfunction

   // One-hot decode of an index into an N-bit mask.
   function automatic logic [N-1:0] one_hot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] mask;
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i == int'(idx));
      end
      return mask;
   endfunction

   logic [N-1:0]     pending_r;
   logic [IDX_W-1:0] rr_ptr_r;
   logic             collision_r;

   logic             valid_s;
   logic             accept_s;
   logic [IDX_W-1:0] sel_idx_s;
   logic [N-1:0]     clr_mask_s;
   logic [N-1:0]     pending_next_s;
   logic [IDX_W-1:0] rr_ptr_next_s;
   logic             collision_next_s;

   // Grant selection and next-state computation from registered state only.
   always_comb begin
      valid_s          = |pending_r;
      sel_idx_s        = '0;
      accept_s         = 1'b0;
      clr_mask_s       = '0;
      rr_ptr_next_s    = rr_ptr_r;

      if (!valid_s) begin
         sel_idx_s = '0;
      end else if (MODE == 1) begin
         sel_idx_s = rr_select(pending_r, rr_ptr_r);
      end else begin
         sel_idx_s = highest_set(pending_r);
      end

      accept_s = valid_s & out_ready;

      if (accept_s) begin
         clr_mask_s = one_hot(sel_idx_s);
      end else begin
         clr_mask_s = '0;
      end

      // A request landing on the bit being accepted re-arms it rather than colliding.
      pending_next_s   = (pending_r & ~clr_mask_s) | req_i;
      collision_next_s = |(req_i & pending_r & ~clr_mask_s);

      if ((MODE == 1) && accept_s) begin
         if (sel_idx_s == LAST_IDX) begin
            rr_ptr_next_s = '0;
         end else begin
            rr_ptr_next_s = sel_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
         end
      end else begin
         rr_ptr_next_s = rr_ptr_r;
      end
   end

   // State registers: pending set, round-robin pointer and collision pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r   <= '0;
         rr_ptr_r    <= '0;
         collision_r <= 1'b0;
      end else begin
         pending_r   <= pending_next_s;
         rr_ptr_r    <= rr_ptr_next_s;
         collision_r <= collision_next_s;
      end
   end

   assign out_valid   = valid_s;
   assign out_idx     = sel_idx_s;
   assign pending_o   = pending_r;
   assign collision_o = collision_r;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench for pending_priority_encoder: fixed-priority N=8, round-robin
// N=8 and round-robin N=5 instances sharing one clock and reset.
module tb_pending_priority_encoder;

   logic       clk;
   logic       rst_n;

   logic [7:0] r0, p0;
   logic       rdy0, v0, c0;
   logic [2:0] i0;

   logic [7:0] r1, p1;
   logic       rdy1, v1, c1;
   logic [2:0] i1;

   logic [4:0] r5, p5;
   logic       rdy5, v5, c5;
   logic [2:0] i5;

   int checks;
   int errors;

   pending_priority_encoder #(.N(8), .MODE(0)) dut_fix (
      .clk(clk), .rst_n(rst_n), .req_i(r0), .out_ready(rdy0),
      .out_valid(v0), .out_idx(i0), .pending_o(p0), .collision_o(c0));

   pending_priority_encoder #(.N(8), .MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_i(r1), .out_ready(rdy1),
      .out_valid(v1), .out_idx(i1), .pending_o(p1), .collision_o(c1));

   pending_priority_encoder #(.N(5), .MODE(1)) dut_rr5 (
      .clk(clk), .rst_n(rst_n), .req_i(r5), .out_ready(rdy5),
      .out_valid(v5), .out_idx(i5), .pending_o(p5), .collision_o(c5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      r0 = 8'h00; r1 = 8'h00; r5 = 5'h00;
      rdy0 = 1'b1; rdy1 = 1'b1; rdy5 = 1'b1;
      tick(); tick();
      checks++; if (v0 !== 1'b0 || i0 !== 3'd0 || p0 !== 8'h00 || c0 !== 1'b0) begin errors++; $display("FAIL reset_fix: v=%b idx=%0d pend=%h col=%b, expected 0 0 00 0", v0, i0, p0, c0); end
      checks++; if (v1 !== 1'b0 || i1 !== 3'd0 || p1 !== 8'h00 || c1 !== 1'b0) begin errors++; $display("FAIL reset_rr: v=%b idx=%0d pend=%h col=%b, expected 0 0 00 0", v1, i1, p1, c1); end
      checks++; if (v5 !== 1'b0 || i5 !== 3'd0 || p5 !== 5'h00 || c5 !== 1'b0) begin errors++; $display("FAIL reset_rr5: v=%b idx=%0d pend=%h col=%b, expected 0 0 00 0", v5, i5, p5, c5); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fixed_onehot();
      logic [2:0] e;
      for (int b = 0; b < 8; b++) begin
         e  = 3'(b);
         r0 = 8'b0000_0001 << b;
         tick();
         r0 = 8'h00;
         checks++; if (v0 !== 1'b1 || i0 !== e) begin errors++; $display("FAIL onehot_grant: v=%b idx=%0d, expected v=1 idx=%0d", v0, i0, e); end
         tick();
         checks++; if (v0 !== 1'b0 || p0 !== 8'h00) begin errors++; $display("FAIL onehot_clear: v=%b pend=%h, expected v=0 pend=00", v0, p0); end
         repeat (8) tick();
      end
   endtask

   task automatic test_fixed_multi();
      r0 = 8'b1001_0010;
      tick();
      r0 = 8'h00;
      checks++; if (v0 !== 1'b1 || i0 !== 3'd7 || c0 !== 1'b0) begin errors++; $display("FAIL multi_first: v=%b idx=%0d col=%b, expected 1 7 0", v0, i0, c0); end
      tick();
      checks++; if (v0 !== 1'b1 || i0 !== 3'd4 || c0 !== 1'b0) begin errors++; $display("FAIL multi_second: v=%b idx=%0d col=%b, expected 1 4 0", v0, i0, c0); end
      tick();
      checks++; if (v0 !== 1'b1 || i0 !== 3'd1 || c0 !== 1'b0) begin errors++; $display("FAIL multi_third: v=%b idx=%0d col=%b, expected 1 1 0", v0, i0, c0); end
      tick();
      checks++; if (v0 !== 1'b0 || i0 !== 3'd0 || c0 !== 1'b0) begin errors++; $display("FAIL multi_empty: v=%b idx=%0d col=%b, expected 0 0 0", v0, i0, c0); end
   endtask

   task automatic test_backpressure();
      rdy0 = 1'b0;
      r0 = 8'b0000_0100;
      tick();
      r0 = 8'h00;
      checks++; if (v0 !== 1'b1 || i0 !== 3'd2 || p0 !== 8'b0000_0100) begin errors++; $display("FAIL bp_hold_low: v=%b idx=%0d pend=%b, expected 1 2 00000100", v0, i0, p0); end
      tick();
      checks++; if (i0 !== 3'd2) begin errors++; $display("FAIL bp_stable: idx=%0d, expected 2", i0); end
      r0 = 8'b0010_0000;
      tick();
      r0 = 8'h00;
      checks++; if (v0 !== 1'b1 || i0 !== 3'd5 || p0 !== 8'b0010_0100) begin errors++; $display("FAIL bp_preempt: v=%b idx=%0d pend=%b, expected 1 5 00100100", v0, i0, p0); end
      rdy0 = 1'b1;
      tick();
      checks++; if (v0 !== 1'b1 || i0 !== 3'd2 || p0 !== 8'b0000_0100) begin errors++; $display("FAIL bp_after5: v=%b idx=%0d pend=%b, expected 1 2 00000100", v0, i0, p0); end
      tick();
      checks++; if (v0 !== 1'b0 || p0 !== 8'h00) begin errors++; $display("FAIL bp_drained: v=%b pend=%h, expected 0 00", v0, p0); end
   endtask

   task automatic test_round_robin();
      logic [2:0] e;
      r1 = 8'hFF;
      tick();
      r1 = 8'h00;
      for (int k = 0; k < 8; k++) begin
         e = 3'(k);
         checks++; if (v1 !== 1'b1 || i1 !== e) begin errors++; $display("FAIL rr_sweep: v=%b idx=%0d, expected v=1 idx=%0d", v1, i1, e); end
         tick();
      end
      checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rr_sweep_empty: v=%b, expected 0", v1); end
      r1 = 8'b0000_0101;
      tick();
      r1 = 8'h00;
      checks++; if (i1 !== 3'd0) begin errors++; $display("FAIL rr_pair_first: idx=%0d, expected 0", i1); end
      tick();
      checks++; if (i1 !== 3'd2) begin errors++; $display("FAIL rr_pair_second: idx=%0d, expected 2", i1); end
      tick();
      checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rr_pair_empty: v=%b, expected 0", v1); end
      // pointer now sits at 3; pending {1,0} must wrap to 0 first
      rdy1 = 1'b0;
      r1 = 8'b0000_0011;
      tick();
      r1 = 8'h00;
      checks++; if (v1 !== 1'b1 || i1 !== 3'd0) begin errors++; $display("FAIL rr_wrap_first: v=%b idx=%0d, expected 1 0", v1, i1); end
      tick();
      checks++; if (i1 !== 3'd0) begin errors++; $display("FAIL rr_wrap_stable: idx=%0d, expected 0", i1); end
      rdy1 = 1'b1;
      tick();
      checks++; if (v1 !== 1'b1 || i1 !== 3'd1) begin errors++; $display("FAIL rr_wrap_second: v=%b idx=%0d, expected 1 1", v1, i1); end
      tick();
      checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rr_wrap_empty: v=%b, expected 0", v1); end
   endtask

   task automatic test_collision();
      rdy0 = 1'b0;
      r0 = 8'b0000_1000;
      tick();
      checks++; if (c0 !== 1'b0 || p0 !== 8'b0000_1000) begin errors++; $display("FAIL col_first_req: col=%b pend=%b, expected 0 00001000", c0, p0); end
      tick();
      r0 = 8'h00;
      checks++; if (c0 !== 1'b1 || p0 !== 8'b0000_1000) begin errors++; $display("FAIL col_pulse: col=%b pend=%b, expected 1 00001000", c0, p0); end
      tick();
      checks++; if (c0 !== 1'b0 || v0 !== 1'b1 || i0 !== 3'd3) begin errors++; $display("FAIL col_one_cycle: col=%b v=%b idx=%0d, expected 0 1 3", c0, v0, i0); end
      rdy0 = 1'b1;
      tick();
      checks++; if (v0 !== 1'b0 || p0 !== 8'h00) begin errors++; $display("FAIL col_single_grant: v=%b pend=%h, expected 0 00", v0, p0); end
      // re-request on the bit being accepted: no collision, bit re-granted
      r0 = 8'b0000_1000;
      tick();
      checks++; if (v0 !== 1'b1 || i0 !== 3'd3) begin errors++; $display("FAIL col_rearm_setup: v=%b idx=%0d, expected 1 3", v0, i0); end
      tick();
      r0 = 8'h00;
      checks++; if (c0 !== 1'b0 || v0 !== 1'b1 || i0 !== 3'd3 || p0 !== 8'b0000_1000) begin errors++; $display("FAIL col_rearm: col=%b v=%b idx=%0d pend=%b, expected 0 1 3 00001000", c0, v0, i0, p0); end
      tick();
      checks++; if (v0 !== 1'b0 || p0 !== 8'h00 || c0 !== 1'b0) begin errors++; $display("FAIL col_rearm_drain: v=%b pend=%h col=%b, expected 0 00 0", v0, p0, c0); end
   endtask

   task automatic test_reset_midstream();
      rdy0 = 1'b0;
      r0 = 8'b0101_0000;
      tick();
      r0 = 8'h00;
      checks++; if (p0 !== 8'b0101_0000 || v0 !== 1'b1 || i0 !== 3'd6) begin errors++; $display("FAIL mid_preload: pend=%b v=%b idx=%0d, expected 01010000 1 6", p0, v0, i0); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (v0 !== 1'b0 || p0 !== 8'h00 || i0 !== 3'd0) begin errors++; $display("FAIL mid_async: v=%b pend=%h idx=%0d, expected 0 00 0", v0, p0, i0); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick(); tick();
      checks++; if (v0 !== 1'b0 || p0 !== 8'h00) begin errors++; $display("FAIL mid_quiet: v=%b pend=%h, expected 0 00", v0, p0); end
      rdy0 = 1'b1;
   endtask

   task automatic test_rr_n5_wrap();
      rdy5 = 1'b1;
      r5 = 5'b1_0000;
      tick();
      r5 = 5'b0_0000;
      checks++; if (v5 !== 1'b1 || i5 !== 3'd4) begin errors++; $display("FAIL n5_top: v=%b idx=%0d, expected 1 4", v5, i5); end
      tick();
      checks++; if (v5 !== 1'b0) begin errors++; $display("FAIL n5_top_drain: v=%b, expected 0", v5); end
      // pointer wrapped to 0, so index 0 beats index 4
      r5 = 5'b1_0001;
      tick();
      r5 = 5'b0_0000;
      checks++; if (i5 !== 3'd0) begin errors++; $display("FAIL n5_wrap_first: idx=%0d, expected 0", i5); end
      tick();
      checks++; if (v5 !== 1'b1 || i5 !== 3'd4) begin errors++; $display("FAIL n5_wrap_second: v=%b idx=%0d, expected 1 4", v5, i5); end
      tick();
      checks++; if (v5 !== 1'b0 || p5 !== 5'b0_0000) begin errors++; $display("FAIL n5_empty: v=%b pend=%b, expected 0 00000", v5, p5); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fixed_onehot();
      test_fixed_multi();
      test_backpressure();
      test_round_robin();
      test_collision();
      test_reset_midstream();
      test_rr_n5_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
